wb_sdram_bridge: RTL and testbench
==================================

// Module: wb_sdram_bridge
// PURPOSE
//  Wishbone-classic slave that converts Caravel user-bus cycles into single-word sdram_controller requests.
//  Sits directly upstream of the SDRAM controller: drives its user_addr/rw/data_in/in_valid and
//    consumes its busy/out_valid/data_out.
//  The controller has no byte mask (DQM fixed 0), so partial writes (sel!=4'hF) become read-modify-write here.
// PARAMETERS
//  BASE_ADDR  32'h3800_0000  window base; hit when wbs_adr_i[31:ADDR_W]==BASE_ADDR[31:ADDR_W]
//  ADDR_W     23             controller address width; ctrl_addr = wbs_adr_i[ADDR_W-1:0]
//  TIMEOUT    10'd1023       max cycles waiting for ctrl_out_valid before error-ack
// PORTS
//  clk             in   1   clock (only clock)
//  rst             in   1   synchronous, active-high reset
//  wbs_cyc_i       in   1   WB cycle
//  wbs_stb_i       in   1   WB strobe
//  wbs_we_i        in   1   1=write
//  wbs_sel_i       in   4   byte enables
//  wbs_adr_i       in   32  byte address
//  wbs_dat_i       in   32  write data
//  wbs_ack_o       out  1   one-cycle ack
//  wbs_dat_o       out  32  read data, valid with ack
//  ctrl_addr       out  23  -> controller user_addr
//  ctrl_rw         out  1   -> rw (1=write)
//  ctrl_data_in    out  32  -> data_in
//  ctrl_in_valid   out  1   -> in_valid, single-cycle pulse
//  ctrl_busy       in   1   <- busy
//  ctrl_out_valid  in   1   <- out_valid
//  ctrl_data_out   in   32  <- data_out
//  err_timeout     out  1   sticky; set on read timeout, cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; timeout counter 0.
//  req = cyc & stb & window hit. Off-window cycles ignored, never acked.
//  FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, ACK.
//   IDLE: on req latch adr/dat/sel/we.
//     -> full write (we & sel==4'hF): WR_ISSUE.
//     -> read, or partial write (we & sel!=F): RD_ISSUE.
//     -> we & sel==0: ACK with no controller access.
//   RD_ISSUE: when !ctrl_busy, pulse ctrl_in_valid=1, ctrl_rw=0 for 1 cycle -> RD_WAIT; else hold.
//   RD_WAIT: count cycles. On ctrl_out_valid capture ctrl_data_out:
//     -> read: wbs_dat_o=data -> ACK.
//     -> partial write: merged[8i+7:8i] = sel[i] ? wdat : rdat -> WR_ISSUE.
//     count reaches TIMEOUT: wbs_dat_o=32'hDEAD_BEEF, err_timeout=1 -> ACK (partial write dropped).
//   WR_ISSUE: when !ctrl_busy, pulse ctrl_in_valid, ctrl_rw=1, ctrl_data_in=merged/full data -> ACK.
//     Write is posted; ack does not wait for SDRAM completion.
//   ACK: wbs_ack_o=1 for exactly one cycle iff cyc&stb still high, else suppressed -> IDLE.
//  ctrl_in_valid never asserted while ctrl_busy=1; never two pulses without a return to a *_ISSUE state.
//  ctrl_addr/rw/data_in stable from pulse cycle until next issue.
//  cyc dropped mid-op: the in-flight controller op completes (incl. RMW write); no ack.
//  ctrl_out_valid outside RD_WAIT is ignored (controller prefetch pulses).
//  Latency: full write ack 2 cycles after req with controller idle; read ack = controller latency + 2.
//  wbs_ack_o never asserted in the same cycle as a new request is latched (no back-to-back acks).
// STRUCTURE
//  Shared package (sdram_pkg): controller address width, WB state encodings, DEAD_BEEF error constant.
//  Single sub-module natural: wb_byte_merge (combinational sel-masked 32-bit merge); FSM stays in top.
// TESTING
//  Full write adr 0x3800_0010 dat 0x1234_5678 sel F -> one in_valid, rw=1, addr 0x10; ack 2 cyc later.
//  Read 0x3800_0010, model returns 0xCAFE_F00D after 5 cyc -> ack with dat_o=0xCAFE_F00D.
//  Partial write sel=4'b0011 dat 0xAAAA_BBBB over stored 0x1111_2222 -> rd, then wr data 0x1111_BBBB.
//  ctrl_busy held high 20 cyc during request -> no in_valid until busy falls, then exactly one pulse.
//  Read with out_valid never returned -> ack at TIMEOUT, dat_o=0xDEAD_BEEF, err_timeout=1.
//  Off-window adr 0x3000_0000 -> no in_valid, no ack; rst mid-RD_WAIT -> outputs 0, FSM=IDLE.

Source files
------------

// File: rtl/wb_sdram_bridge_pkg.sv
// Shared definitions for the Wishbone-to-SDRAM-controller bridge.
package wb_sdram_bridge_pkg;

    localparam int          CTRL_ADDR_W = 23;
    localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
    localparam logic [3:0]  SEL_ALL     = 4'hF;
    localparam logic [3:0]  SEL_NONE    = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_ACK      = 3'd4
    } wb_state_e;

    // A write that covers every byte can go straight to the controller.
    function automatic logic is_full_write(input logic we, input logic [3:0] sel);
        return we && (sel == SEL_ALL);
    endfunction

endpackage

// File: rtl/wb_sdram_bridge_if.sv
// Wishbone-classic slave bus bundle as seen by the bridge.
interface wb_sdram_bridge_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_sdram_bridge_byte_merge.sv
// Byte-lane merge for read-modify-write: selected lanes take the new write
// data, the rest keep what was read back from SDRAM.
module wb_byte_merge (
    input  logic [3:0]  sel,
    input  logic [31:0] wdat,
    input  logic [31:0] rdat,
    output logic [31:0] merged
);

    // Lane-by-lane select between write data and read data.
    always_comb begin
        merged = rdat;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = wdat[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_sdram_bridge.sv
// Wishbone-classic slave turning user-bus cycles into single-word SDRAM
// controller requests; partial writes become read-modify-write.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for a window hit; latches adr/dat/sel/we
// ST_RD_ISSUE | read pulse pending, held off while controller is busy
// ST_RD_WAIT  | waiting for out_valid, timeout down-counter running
// ST_WR_ISSUE | write pulse pending (full or merged data), held off on busy
// ST_ACK      | one-cycle ack, gated by cyc&stb still being high
module wb_sdram_bridge
    import wb_sdram_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
    parameter int          ADDR_W    = CTRL_ADDR_W,
    parameter logic [9:0]  TIMEOUT   = 10'd1023
) (
    input  logic              clk,
    input  logic              rst,
    wb_sdram_bridge_if.slave  wb,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic              ctrl_rw,
    output logic [31:0]       ctrl_data_in,
    output logic              ctrl_in_valid,
    input  logic              ctrl_busy,
    input  logic              ctrl_out_valid,
    input  logic [31:0]       ctrl_data_out,
    output logic              err_timeout
);

    wb_state_e         state_q, state_d;
    logic              req;
    logic              timeout_hit;
    logic              ack_c;
    logic              in_valid_c;
    logic [ADDR_W-1:0] adr_q;
    logic [31:0]       wdat_q;
    logic [3:0]        sel_q;
    logic              we_q;
    logic              rw_q;
    logic [31:0]       data_in_q;
    logic [31:0]       rdat_q;
    logic              err_q;
    logic [9:0]        cnt_q;
    logic [31:0]       merged;

    assign req = wb.wbs_cyc_i && wb.wbs_stb_i &&
                 (wb.wbs_adr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);

    // Last RD_WAIT cycle with no data: give up and error-ack.
    assign timeout_hit = (state_q == ST_RD_WAIT) && !ctrl_out_valid && (cnt_q <= 10'd1);

    wb_byte_merge u_merge (
        .sel    (sel_q),
        .wdat   (wdat_q),
        .rdat   (ctrl_data_out),
        .merged (merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the in_valid pulse and the ack, which are decoded from state.
    always_comb begin
        state_d    = state_q;
        in_valid_c = 1'b0;
        ack_c      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (is_full_write(wb.wbs_we_i, wb.wbs_sel_i)) begin
                        state_d = ST_WR_ISSUE;
                    end else if (wb.wbs_we_i && (wb.wbs_sel_i == SEL_NONE)) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                if (!ctrl_busy) begin
                    in_valid_c = 1'b1;
                    state_d    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (ctrl_out_valid) begin
                    state_d = we_q ? ST_WR_ISSUE : ST_ACK;
                end else if (timeout_hit) begin
                    state_d = ST_ACK;
                end
            end
            ST_WR_ISSUE: begin
                if (!ctrl_busy) begin
                    in_valid_c = 1'b1;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_c   = wb.wbs_cyc_i && wb.wbs_stb_i;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, controller command registers, read data and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rw_q      <= 1'b0;
            data_in_q <= '0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if ((state_q == ST_IDLE) && req) begin
                adr_q  <= wb.wbs_adr_i[ADDR_W-1:0];
                wdat_q <= wb.wbs_dat_i;
                sel_q  <= wb.wbs_sel_i;
                we_q   <= wb.wbs_we_i;
            end
            // Command fields change only on entry to an issue state, so they
            // stay put from the pulse until the next operation.
            if ((state_d == ST_WR_ISSUE) && (state_q != ST_WR_ISSUE)) begin
                rw_q      <= 1'b1;
                data_in_q <= (state_q == ST_IDLE) ? wb.wbs_dat_i : merged;
            end
            if ((state_d == ST_RD_ISSUE) && (state_q != ST_RD_ISSUE)) begin
                rw_q <= 1'b0;
            end
            if (state_d != ST_RD_WAIT) begin
                cnt_q <= '0;
            end else if (state_q == ST_RD_ISSUE) begin
                cnt_q <= TIMEOUT;
            end else begin
                cnt_q <= cnt_q - 10'd1;
            end
            if ((state_q == ST_RD_WAIT) && ctrl_out_valid && !we_q) begin
                rdat_q <= ctrl_data_out;
            end
            if (timeout_hit) begin
                rdat_q <= ERR_DATA;
                err_q  <= 1'b1;
            end
        end
    end

    assign ctrl_addr     = adr_q;
    assign ctrl_rw       = rw_q;
    assign ctrl_data_in  = data_in_q;
    assign ctrl_in_valid = in_valid_c;
    assign err_timeout   = err_q;
    assign wb.wbs_ack_o  = ack_c;
    assign wb.wbs_dat_o  = rdat_q;

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Bench for wb_sdram_bridge: behavioural SDRAM controller, reference memory
// with byte-masked writes, and an expected-command queue checked every cycle.
module tb_wb_sdram_bridge;

    localparam int         LAT = 5;
    localparam logic [9:0] TMO = 10'd1023;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] ctrl_addr;
    logic        ctrl_rw;
    logic [31:0] ctrl_data_in;
    logic        ctrl_in_valid;
    logic        ctrl_busy;
    logic        ctrl_out_valid;
    logic [31:0] ctrl_data_out;
    logic        err_timeout;

    always #5 clk = ~clk;

    wb_sdram_bridge_if wb ();

    wb_sdram_bridge #(
        .BASE_ADDR (32'h3800_0000),
        .ADDR_W    (23),
        .TIMEOUT   (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb             (wb),
        .ctrl_addr      (ctrl_addr),
        .ctrl_rw        (ctrl_rw),
        .ctrl_data_in   (ctrl_data_in),
        .ctrl_in_valid  (ctrl_in_valid),
        .ctrl_busy      (ctrl_busy),
        .ctrl_out_valid (ctrl_out_valid),
        .ctrl_data_out  (ctrl_data_out),
        .err_timeout    (err_timeout)
    );

    typedef struct {
        logic        rw;
        logic [22:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         exp_q[$];
    op_t         cur_op;
    logic [31:0] ref_mem[logic [22:0]];
    logic [31:0] ctl_mem[logic [22:0]];
    int          errors = 0;
    int          checks = 0;
    bit          ack_allowed = 0;
    bit          no_resp = 0;
    bit          stray_req = 0;
    int          rd_cnt = 0;
    logic [22:0] rd_addr = '0;
    int          iv_total = 0;
    int          ack_total = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_rd(input logic [22:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = 32'h0;
        if (sel[0]) m = m + 32'h0000_00FF;
        if (sel[1]) m = m + 32'h0000_FF00;
        if (sel[2]) m = m + 32'h00FF_0000;
        if (sel[3]) m = m + 32'hFF00_0000;
        return m;
    endfunction

    // Every-cycle compare of controller commands and acks, then the controller model.
    always @(negedge clk) begin
        if (rst) begin
            rd_cnt         = 0;
            ctrl_out_valid = 1'b0;
            ctrl_data_out  = 32'h0;
        end else begin
            if (wb.wbs_ack_o) begin
                ack_total++;
                checks++;
                if (!ack_allowed) begin
                    errors++;
                    $display("FAIL unexpected_ack: got ack=1 expected ack=0");
                end
            end
            if (ctrl_in_valid) begin
                iv_total++;
                check32("in_valid_while_busy", {31'b0, ctrl_busy}, 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_in_valid: got pulse addr=%h rw=%0d expected none", ctrl_addr, ctrl_rw);
                end else begin
                    cur_op = exp_q.pop_front();
                    check32("ctrl_rw", {31'b0, ctrl_rw}, {31'b0, cur_op.rw});
                    check32("ctrl_addr", {9'b0, ctrl_addr}, {9'b0, cur_op.addr});
                    if (cur_op.rw) check32("ctrl_data_in", ctrl_data_in, cur_op.data);
                end
            end
            ctrl_out_valid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    ctrl_out_valid = 1'b1;
                    ctrl_data_out  = ctl_mem.exists(rd_addr) ? ctl_mem[rd_addr] : 32'h0;
                end
            end
            if (stray_req) begin
                ctrl_out_valid = 1'b1;
                ctrl_data_out  = 32'h5A5A_5A5A;
                stray_req      = 0;
            end
            if (ctrl_in_valid) begin
                if (ctrl_rw) begin
                    ctl_mem[ctrl_addr] = ctrl_data_in;
                end else if (!no_resp) begin
                    rd_cnt  = LAT;
                    rd_addr = ctrl_addr;
                end
            end
        end
    end

    // One WB classic cycle; latency is counted in clock edges from the
    // latching edge to the edge where the master samples ack.
    task automatic wb_access(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                             input logic [31:0] dat, input int exp_lat, input bit chk_data,
                             input logic [31:0] exp_dat, input string name);
        int n;
        bit got;
        n   = 0;
        got = 0;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        ack_allowed  = 1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (wb.wbs_ack_o) begin
                got = 1;
                break;
            end
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_ack: got no ack expected ack within 2000 cycles", name);
        end else begin
            check32({name, "_latency"}, n, exp_lat);
            if (chk_data) check32({name, "_rdata"}, wb.wbs_dat_o, exp_dat);
        end
        step();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        ack_allowed  = 0;
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input int extra, input string name);
        logic [22:0] a;
        logic [31:0] m;
        int          lat;
        a = adr[22:0];
        if (sel == 4'hF) begin
            exp_q.push_back('{rw: 1'b1, addr: a, data: dat});
            ref_mem[a] = dat;
            lat = 2;
        end else if (sel == 4'h0) begin
            lat = 1;
        end else begin
            m = (dat & lane_mask(sel)) | (ref_rd(a) & ~lane_mask(sel));
            exp_q.push_back('{rw: 1'b0, addr: a, data: 32'h0});
            exp_q.push_back('{rw: 1'b1, addr: a, data: m});
            ref_mem[a] = m;
            lat = LAT + 3;
        end
        wb_access(1'b1, sel, adr, dat, lat + extra, 0, 32'h0, name);
    endtask

    task automatic do_read(input logic [31:0] adr, input string name);
        exp_q.push_back('{rw: 1'b0, addr: adr[22:0], data: 32'h0});
        wb_access(1'b0, 4'hF, adr, 32'h0, LAT + 2, 1, ref_rd(adr[22:0]), name);
    endtask

    initial begin
        int iv0;
        int ack0;
        rst          = 1'b1;
        ctrl_busy    = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'h0;
        wb.wbs_dat_i = 32'h0;
        repeat (3) step();
        check32("rst_ack", {31'b0, wb.wbs_ack_o}, 32'h0);
        check32("rst_in_valid", {31'b0, ctrl_in_valid}, 32'h0);
        check32("rst_dat_o", wb.wbs_dat_o, 32'h0);
        check32("rst_err", {31'b0, err_timeout}, 32'h0);
        rst = 1'b0;
        step();

        do_write(32'h3800_0010, 32'h1234_5678, 4'hF, 0, "wr_full");
        do_read(32'h3800_0010, "rd_10");
        check32("rd_10_literal", wb.wbs_dat_o, 32'h1234_5678);
        do_write(32'h3800_0014, 32'hCAFE_F00D, 4'hF, 0, "wr_14");
        do_read(32'h3800_0014, "rd_14");
        check32("rd_14_literal", wb.wbs_dat_o, 32'hCAFE_F00D);

        do_write(32'h3800_0020, 32'h1111_2222, 4'hF, 0, "wr_20");
        do_write(32'h3800_0020, 32'hAAAA_BBBB, 4'b0011, 0, "wr_rmw");
        do_read(32'h3800_0020, "rd_20");
        check32("rmw_literal", wb.wbs_dat_o, 32'h1111_BBBB);
        do_write(32'h3800_0020, 32'hFFFF_FFFF, 4'h0, 0, "wr_sel0");
        do_read(32'h3800_0020, "rd_20_after_sel0");

        iv0 = iv_total;
        ctrl_busy = 1'b1;
        fork
            begin
                repeat (20) step();
                ctrl_busy = 1'b0;
            end
        join_none
        do_write(32'h3800_0040, 32'h0BAD_F00D, 4'hF, 19, "wr_busy");
        check32("busy_pulses", iv_total - iv0, 32'd1);

        iv0  = iv_total;
        ack0 = ack_total;
        stray_req = 1;
        repeat (5) step();
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = 32'h3000_0000;
        repeat (10) step();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        step();
        check32("offwin_in_valid", iv_total - iv0, 32'd0);
        check32("offwin_ack", ack_total - ack0, 32'd0);

        do_write(32'h3800_0030, 32'h5555_6666, 4'hF, 0, "wr_30");
        exp_q.push_back('{rw: 1'b0, addr: 23'h30, data: 32'h0});
        exp_q.push_back('{rw: 1'b1, addr: 23'h30,
                          data: (32'h7777_8888 & lane_mask(4'b1100)) | (ref_rd(23'h30) & ~lane_mask(4'b1100))});
        ref_mem[23'h30] = (32'h7777_8888 & lane_mask(4'b1100)) | (ref_rd(23'h30) & ~lane_mask(4'b1100));
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_sel_i = 4'b1100;
        wb.wbs_adr_i = 32'h3800_0030;
        wb.wbs_dat_i = 32'h7777_8888;
        repeat (2) step();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        repeat (15) step();
        check32("cyc_drop_ops_done", exp_q.size(), 32'd0);
        do_read(32'h3800_0030, "rd_30");
        check32("cyc_drop_literal", wb.wbs_dat_o, 32'h7777_6666);

        no_resp = 1;
        exp_q.push_back('{rw: 1'b0, addr: 23'h10, data: 32'h0});
        wb_access(1'b0, 4'hF, 32'h3800_0010, 32'h0, int'(TMO) + 2, 1, 32'hDEAD_BEEF, "rd_timeout");
        no_resp = 0;
        check32("err_set", {31'b0, err_timeout}, 32'h1);
        do_read(32'h3800_0014, "rd_after_timeout");
        check32("err_sticky", {31'b0, err_timeout}, 32'h1);

        no_resp = 1;
        exp_q.push_back('{rw: 1'b0, addr: 23'h10, data: 32'h0});
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_adr_i = 32'h3800_0010;
        repeat (8) step();
        rst = 1'b1;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        repeat (2) step();
        check32("midrst_in_valid", {31'b0, ctrl_in_valid}, 32'h0);
        check32("midrst_addr", {9'b0, ctrl_addr}, 32'h0);
        check32("midrst_rw", {31'b0, ctrl_rw}, 32'h0);
        check32("midrst_data_in", ctrl_data_in, 32'h0);
        check32("midrst_dat_o", wb.wbs_dat_o, 32'h0);
        check32("midrst_err", {31'b0, err_timeout}, 32'h0);
        rst = 1'b0;
        no_resp = 0;
        step();
        do_read(32'h3800_0014, "rd_after_rst");
        check32("rd_after_rst_literal", wb.wbs_dat_o, 32'hCAFE_F00D);

        repeat (3) step();
        check32("exp_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
